// File: rtl/ofifo_egress_sched.sv
// Packet-granular round-robin drain of four show-ahead FIFOs onto one stream.
// Define OFIFO_EGRESS_SCHED_TIMEOUT_EN to add the mid-packet starvation timeout.
module ofifo_egress_sched #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 16,
    parameter int EOP_BIT   = 15
`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        fpo_empty,
    input  logic [NUM_PORTS*DATA_W-1:0] fpo_data,
    input  logic [NUM_PORTS*TAG_W-1:0]  fpo_ptag,
    output logic [NUM_PORTS-1:0]        acc_rd,
    output logic [DATA_W-1:0]           eg_data,
    output logic [TAG_W-1:0]            eg_ptag,
    output logic [1:0]                  eg_src,
    output logic                        eg_sop,
    output logic                        eg_valid,
    input  logic                        eg_ready,
    output logic                        busy,
    output logic                        err_timeout
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t             state_q, state_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         grant_q, grant_d;
    logic               sop_q, sop_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TAG_W-1:0]   ptag_q, ptag_d;
    logic [1:0]         src_q, src_d;
    logic               esop_q, esop_d;
    logic               valid_q, valid_d;

    logic               load;
    logic               found;
    logic [1:0]         idx;
    logic [DATA_W-1:0]  head_data;
    logic [TAG_W-1:0]   head_tag;

`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
`endif

    assign head_data = fpo_data[int'(grant_q)*DATA_W +: DATA_W];
    assign head_tag  = fpo_ptag[int'(grant_q)*TAG_W +: TAG_W];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        sop_d   = sop_q;
        data_d  = data_q;
        ptag_d  = ptag_q;
        src_d   = src_q;
        esop_d  = esop_q;
        valid_d = valid_q;
        load    = 1'b0;
        found   = 1'b0;
        idx     = '0;
        acc_rd  = '0;
`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    idx = rr_q + 2'(i);
                    if (!found && !fpo_empty[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                    end
                end
                if (found) begin
                    state_d = XFER;
                    sop_d   = 1'b1;
                end
            end
            XFER: begin
                load = !fpo_empty[grant_q] && (!valid_q || eg_ready);
                if (load) begin
                    acc_rd[grant_q] = 1'b1;
                    data_d  = head_data;
                    ptag_d  = head_tag;
                    src_d   = grant_q;
                    esop_d  = sop_q;
                    sop_d   = 1'b0;
                    valid_d = 1'b1;
                    if (head_tag[EOP_BIT]) begin
                        state_d = IDLE;
                        rr_d    = grant_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase

        // Retire the held word when the stage is not refilled this cycle.
        if (!load && valid_q && eg_ready)
            valid_d = 1'b0;

`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
        if (state_q != XFER || load) begin
            cnt_d = '0;
        end else if (fpo_empty[grant_q]) begin
            if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                rr_d    = grant_q + 2'd1;
                err_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            sop_q   <= 1'b0;
            data_q  <= '0;
            ptag_q  <= '0;
            src_q   <= '0;
            esop_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            sop_q   <= sop_d;
            data_q  <= data_d;
            ptag_q  <= ptag_d;
            src_q   <= src_d;
            esop_q  <= esop_d;
            valid_q <= valid_d;
        end
    end

`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign eg_data  = data_q;
    assign eg_ptag  = ptag_q;
    assign eg_src   = src_q;
    assign eg_sop   = esop_q;
    assign eg_valid = valid_q;
    assign busy     = (state_q == XFER);

endmodule

// File: tb/tb_ofifo_egress_sched.sv
// Directed bench for ofifo_egress_sched: cycle table for the basic
// round robin, then hand sequences for the multi-cycle corner cases.
module tb_ofifo_egress_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   fpo_empty;
    logic [127:0] fpo_data;
    logic [63:0]  fpo_ptag;
    logic [3:0]   acc_rd;
    logic [31:0]  eg_data;
    logic [15:0]  eg_ptag;
    logic [1:0]   eg_src;
    logic         eg_sop;
    logic         eg_valid;
    logic         eg_ready;
    logic         busy;
    logic         err_timeout;

    ofifo_egress_sched dut (
        .clk         (clk),
        .reset       (reset),
        .fpo_empty   (fpo_empty),
        .fpo_data    (fpo_data),
        .fpo_ptag    (fpo_ptag),
        .acc_rd      (acc_rd),
        .eg_data     (eg_data),
        .eg_ptag     (eg_ptag),
        .eg_src      (eg_src),
        .eg_sop      (eg_sop),
        .eg_valid    (eg_valid),
        .eg_ready    (eg_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [15:0] t;
    } fent_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
        logic [15:0] tag;
        logic        sop;
    } word_t;

    typedef struct {
        logic        rdy;
        logic        busy;
        logic [3:0]  rd;
        logic        vld;
        logic [1:0]  src;
        logic        sop;
        logic [31:0] data;
    } vec_t;

    fent_t fq[4][$];
    word_t got[$];
    word_t exp_q[$];
    vec_t  tv[13];
    int    errors = 0;
    int    checks = 0;
    logic [3:0] rd_s;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            fpo_empty[i] = (fq[i].size() == 0);
            fpo_data[i*32 +: 32] = fq[i].size() ? fq[i][0].d : 32'h0;
            fpo_ptag[i*16 +: 16] = fq[i].size() ? fq[i][0].t : 16'h0;
        end
    endtask

    task automatic push(input int p, input logic [31:0] d,
                        input logic [15:0] t);
        fq[p].push_back('{d, t});
        refresh();
    endtask

    task automatic exp_add(input int p, input logic [31:0] d,
                           input logic [15:0] t, input logic sop);
        exp_q.push_back('{2'(p), d, t, sop});
    endtask

    task automatic pkt(input int p, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            logic [15:0] t;
            t = (k == n - 1) ? 16'h8000 : 16'h0000;
            push(p, base + 32'(k), t);
            exp_add(p, base + 32'(k), t, k == 0);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        int cyc;
        n = exp_q.size();
        cyc = 0;
        while (got.size() < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        chk($sformatf("%s_count", nm), got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("%s_src%0d", nm, i), got[i].src, exp_q[i].src);
            chk($sformatf("%s_data%0d", nm, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s_tag%0d", nm, i), got[i].tag, exp_q[i].tag);
            chk($sformatf("%s_sop%0d", nm, i), got[i].sop, exp_q[i].sop);
        end
        got.delete();
        exp_q.delete();
    endtask

    // FIFO model: pop on the edge where acc_rd was high.
    initial begin
        forever begin
            @(posedge clk);
            rd_s = acc_rd;
            #1;
            for (int i = 0; i < 4; i++)
                if (rd_s[i] && fq[i].size() > 0)
                    fq[i].delete(0);
            refresh();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!reset && eg_valid && eg_ready)
                got.push_back('{eg_src, eg_data, eg_ptag, eg_sop});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rd_onehot", 32'($countones(acc_rd) <= 1), 32'd1);
            chk("rd_nonempty", acc_rd & fpo_empty, 32'd0);
            if (!busy)
                chk("rd_idle", acc_rd, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int starve;
        reset    = 1'b1;
        eg_ready = 1'b1;
        refresh();

        tv[0]  = '{1'b1, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 32'h0};
        tv[1]  = '{1'b1, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 32'hA000_0000};
        tv[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 32'hA000_0001};
        tv[3]  = '{1'b1, 1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 32'hA000_0100};
        tv[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b0, 32'hA000_0101};
        tv[6]  = '{1'b1, 1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 32'hA000_0200};
        tv[8]  = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 32'hA000_0201};
        tv[9]  = '{1'b1, 1'b1, 4'h8, 1'b0, 2'd0, 1'b0, 32'h0};
        tv[10] = '{1'b1, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 32'hA000_0300};
        tv[11] = '{1'b1, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 32'hA000_0301};
        tv[12] = '{1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};

        for (int p = 0; p < 4; p++)
            pkt(p, 2, 32'hA000_0000 + 32'(p * 256));

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acc_rd", acc_rd, 0);
        chk("rst_valid", eg_valid, 0);
        chk("rst_sop", eg_sop, 0);
        chk("rst_data", eg_data, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b0;

        for (int k = 0; k < 13; k++) begin
            eg_ready = tv[k].rdy;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t1_busy%0d", k), busy, tv[k].busy);
            chk($sformatf("t1_rd%0d", k), acc_rd, tv[k].rd);
            chk($sformatf("t1_vld%0d", k), eg_valid, tv[k].vld);
            if (tv[k].vld) begin
                chk($sformatf("t1_src%0d", k), eg_src, tv[k].src);
                chk($sformatf("t1_sop%0d", k), eg_sop, tv[k].sop);
                chk($sformatf("t1_data%0d", k), eg_data, tv[k].data);
            end
        end
        got.delete();
        exp_q.delete();

        // Single-word packet leaves rr_ptr at 1.
        pkt(0, 1, 32'hB000_0000);
        drain("t2a");
        pkt(2, 4, 32'hC000_0200);
        pkt(0, 1, 32'hC000_0000);
        drain("t2");

        // Backpressure in mid-packet.
        pkt(1, 4, 32'hD000_0100);
        cyc = 0;
        while (!eg_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_started", eg_valid, 1);
        eg_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t3_hold_data%0d", k), eg_data, 32'hD000_0100);
            chk($sformatf("t3_hold_sop%0d", k), eg_sop, 1);
            chk($sformatf("t3_hold_vld%0d", k), eg_valid, 1);
            chk($sformatf("t3_hold_rd%0d", k), acc_rd, 0);
            chk($sformatf("t3_hold_fifo%0d", k), fq[1].size(), 3);
        end
        eg_ready = 1'b1;
        drain("t3");

        // Granted FIFO1 starves mid-packet while FIFO3 waits.
        push(1, 32'hE000_0100, 16'h0000);
        push(1, 32'hE000_0101, 16'h0000);
        exp_add(1, 32'hE000_0100, 16'h0000, 1'b1);
        exp_add(1, 32'hE000_0101, 16'h0000, 1'b0);
        exp_add(1, 32'hE000_0102, 16'h0000, 1'b0);
        exp_add(1, 32'hE000_0103, 16'h8000, 1'b0);
        repeat (5) @(negedge clk);
        push(3, 32'hE000_0300, 16'h8000);
        exp_add(3, 32'hE000_0300, 16'h8000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t4_busy%0d", k), busy, 1);
            chk($sformatf("t4_rd%0d", k), acc_rd, 0);
            chk($sformatf("t4_fifo3_%0d", k), fq[3].size(), 1);
        end
        push(1, 32'hE000_0102, 16'h0000);
        push(1, 32'hE000_0103, 16'h8000);
        drain("t4");

        // Asynchronous reset in mid-packet.
        pkt(2, 4, 32'hF000_0200);
        exp_q.delete();
        cyc = 0;
        while (!eg_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_started", eg_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_rd", acc_rd, 0);
        chk("t5_async_vld", eg_valid, 0);
        chk("t5_async_sop", eg_sop, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_data", eg_data, 0);
        chk("t5_async_src", eg_src, 0);
        got.delete();
        @(negedge clk);
        push(1, 32'hF000_0100, 16'h8000);
        exp_add(1, 32'hF000_0100, 16'h8000, 1'b1);
        for (int k = 0; k < fq[2].size(); k++)
            exp_add(2, fq[2][k].d, fq[2][k].t, k == 0);
        @(negedge clk);
        reset = 1'b0;
        drain("t5");

`ifdef OFIFO_EGRESS_SCHED_TIMEOUT_EN
        push(0, 32'h9000_0000, 16'h0000);
        exp_add(0, 32'h9000_0000, 16'h0000, 1'b1);
        pkt(1, 1, 32'h9000_0100);
        cyc = 0;
        starve = 0;
        while (!err_timeout && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!err_timeout && busy && fpo_empty[0])
                starve++;
        end
        chk("t6_err", err_timeout, 1);
        chk("t6_starve_cycles", starve, 64);
        chk("t6_busy", busy, 0);
        chk("t6_fifo1_untouched", fq[1].size(), 1);
        drain("t6");
        chk("t6_sticky", err_timeout, 1);
`else
        chk("err_tied_low", err_timeout, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
